// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the nibble-serial ripple-carry sequencer.
package rca_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibbles (and RUN cycles) needed for a given operand width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice shared by the sequencer.
module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder controller: time-shares one add4_slice across WIDTH/4
// cycles, registering the carry between nibbles.
// Optional build macro RCA_SEQ_SUB_EN adds a 'sub' port for a - b.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     sum_q, sum_d;
`ifdef RCA_SEQ_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_cout;

  // Feed the current nibble of the latched operands into the shared slice;
  // subtraction inverts b (the +1 comes from the forced initial carry).
  always_comb begin
    sl_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    sl_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`ifdef RCA_SEQ_SUB_EN
    if (sub_q) sl_b = ~b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`endif
  end

  add4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // Next-state logic: accept in IDLE/DONE, one nibble per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef RCA_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Latch operands and wipe the previous result before nibble 0.
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = cin;
`ifdef RCA_SEQ_SUB_EN
          sub_d   = sub;
          if (sub) carry_d = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_s;
        carry_d = sl_cout;
        if (idx_q == IDX_W'(NIB - 1)) begin
          sum_d[WIDTH] = sl_cout;
          idx_d        = '0;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef RCA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef RCA_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WIDTH=16); sub tests under RCA_SEQ_SUB_EN.
module tb_rca_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef RCA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy, done;
  logic [WIDTH:0]   sum;

  int ntests = 0;
  int nfail  = 0;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start at the current negedge, drop it one cycle later (cycle T+1).
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv);
    a = av; b = bv; cin = cv; start = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub ignored in add-only build");
`endif
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;  // prove only latched copies are used
  endtask

  // Starting in cycle T+1: busy for 4 cycles, then done with the result.
  task automatic body(input logic [WIDTH:0] exp, input string tag);
    chk({tag, ".clr"}, sum, 17'h0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      chk({tag, ".busy"}, {16'h0, busy}, 17'h1);
      chk({tag, ".nodone"}, {16'h0, done}, 17'h0);
    end
    @(negedge clk);
    chk({tag, ".done"}, {16'h0, done}, 17'h1);
    chk({tag, ".idle"}, {16'h0, busy}, 17'h0);
    chk({tag, ".sum"}, sum, exp);
  endtask

  task automatic after_done(input logic [WIDTH:0] exp, input string tag);
    @(negedge clk);
    chk({tag, ".pulse"}, {16'h0, done}, 17'h0);
    chk({tag, ".hold"}, sum, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    // Start during reset must be dropped.
    start = 1'b1; a = 16'h1111;
    @(negedge clk);
    chk("rst.busy", {16'h0, busy}, 17'h0);
    chk("rst.done", {16'h0, done}, 17'h0);
    chk("rst.sum", sum, 17'h0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst.idle", {16'h0, busy}, 17'h0);

    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    body(17'h05555, "basic");
    after_done(17'h05555, "basic");

    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    body(17'h10000, "ripple");
    after_done(17'h10000, "ripple");

    // Max operands with carry-in, then restart directly from DONE.
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    body(17'h1FFFF, "max");
    launch(16'h00FF, 16'h0F01, 1'b1, 1'b0);
    body(17'h01001, "chain");
    after_done(17'h01001, "chain");

    // Start while busy is ignored.
    launch(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("ign.b1", {16'h0, busy}, 17'h1);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    chk("ign.b2", {16'h0, busy}, 17'h1);
    @(negedge clk);
    start = 1'b0;
    chk("ign.b3", {16'h0, busy}, 17'h1);
    @(negedge clk);
    chk("ign.b4", {16'h0, busy}, 17'h1);
    @(negedge clk);
    chk("ign.done", {16'h0, done}, 17'h1);
    chk("ign.sum", sum, 17'h00002);
    after_done(17'h00002, "ign");
    chk("ign.nobusy", {16'h0, busy}, 17'h0);

    // Reset on RUN cycle 2 discards the partial result.
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst.busy", {16'h0, busy}, 17'h0);
    chk("mrst.done", {16'h0, done}, 17'h0);
    chk("mrst.sum", sum, 17'h0);
    @(negedge clk);
    launch(16'hABCD, 16'h1111, 1'b0, 1'b0);
    body(17'h0BCDE, "postrst");
    after_done(17'h0BCDE, "postrst");

`ifdef RCA_SEQ_SUB_EN
    launch(16'h0005, 16'h0007, 1'b0, 1'b1);
    body(17'h0FFFE, "sub.borrow");
    after_done(17'h0FFFE, "sub.borrow");
    launch(16'h0007, 16'h0005, 1'b0, 1'b1);
    body(17'h10002, "sub.pos");
    after_done(17'h10002, "sub.pos");
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
